// File: rtl/alu_seq.sv
// Sequenced command front end for the 16-bit ALU: valid/ready request in, registered
// response out, with multi-pass SUB/SLT/ROTR and a shift-add MUL built on ALU passes.
module alu_seq #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [3:0]   req_cmd,
  input  logic [N-1:0] req_a,
  input  logic [N-1:0] req_b,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [N-1:0] rsp_data,
  output logic         rsp_zero,
  output logic         rsp_ofl,
  output logic         rsp_err,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic         alu_cin,
  output logic         alu_inva,
  output logic         alu_invb,
  output logic         alu_sign,
  output logic [2:0]   alu_op,
  input  logic [N-1:0] alu_out,
  input  logic         alu_zero,
  input  logic         alu_ofl
);

  typedef enum logic [2:0] {S_IDLE, S_EXEC, S_EXEC2, S_MUL, S_RESP} state_t;

  typedef struct packed {
    logic [3:0]   cmd;
    logic [N-1:0] a;
    logic [N-1:0] b;
  } req_t;

  localparam logic [3:0] CMD_ADD  = 4'd4;
  localparam logic [3:0] CMD_SUB  = 4'd8;
  localparam logic [3:0] CMD_SLT  = 4'd9;
  localparam logic [3:0] CMD_ROTR = 4'd10;
  localparam logic [3:0] CMD_MUL  = 4'd11;

  state_t       state, state_d;
  req_t         req_q;
  logic [N-1:0] shamt_q;
  logic [N-1:0] acc_q, mcand_q, mplier_q;
  logic [3:0]   cnt_q;
  logic         mofl_q;

  logic [N-1:0] exec_data;
  logic         exec_ofl;
  logic [N-1:0] acc_n;
  logic         mofl_n;

  // Zero flag comes from the ALU-independent result register.
  logic unused;
  assign unused = alu_zero;

  // Next state, handshake and ALU drive.
  always_comb begin
    state_d   = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    alu_a     = '0;
    alu_b     = '0;
    alu_cin   = 1'b0;
    alu_inva  = 1'b0;
    alu_invb  = 1'b0;
    alu_sign  = 1'b0;
    alu_op    = 3'b000;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_cmd <= CMD_ROTR)    state_d = S_EXEC;
          else if (req_cmd == CMD_MUL) state_d = S_MUL;
          else                         state_d = S_RESP;
        end
      end
      S_EXEC: begin
        alu_sign = 1'b1;
        if (req_q.cmd[3] == 1'b0) begin
          alu_a  = req_q.a;
          alu_b  = req_q.b;
          alu_op = req_q.cmd[2:0];
        end else begin
          // SUB/SLT compute A-B; ROTR computes 0-B as the left-rotate count.
          alu_a    = (req_q.cmd == CMD_ROTR) ? '0 : req_q.a;
          alu_b    = req_q.b;
          alu_invb = 1'b1;
          alu_cin  = 1'b1;
          alu_op   = 3'b100;
        end
        state_d = (req_q.cmd == CMD_ROTR) ? S_EXEC2 : S_RESP;
      end
      S_EXEC2: begin
        alu_a    = req_q.a;
        alu_b    = shamt_q;
        alu_sign = 1'b1;
        alu_op   = 3'b000;
        state_d  = S_RESP;
      end
      S_MUL: begin
        alu_a   = acc_q;
        alu_b   = mcand_q;
        alu_op  = 3'b100;
        if (cnt_q == 4'd15) state_d = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Result shaping for the single-pass group (cmds 0-9).
  always_comb begin
    exec_data = alu_out;
    exec_ofl  = 1'b0;
    case (req_q.cmd)
      CMD_ADD, CMD_SUB: exec_ofl = alu_ofl;
      CMD_SLT:          exec_data = {{(N-1){1'b0}}, alu_out[N-1] ^ alu_ofl};
      default:          ;
    endcase
  end

  always_comb begin
    acc_n  = acc_q;
    mofl_n = mofl_q;
    if (mplier_q[0]) begin
      acc_n  = alu_out;
      mofl_n = mofl_q | alu_ofl;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q    <= '0;
      shamt_q  <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      mofl_q   <= 1'b0;
      rsp_data <= '0;
      rsp_ofl  <= 1'b0;
      rsp_err  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (req_valid) begin
          req_q    <= '{cmd: req_cmd, a: req_a, b: req_b};
          acc_q    <= '0;
          mcand_q  <= req_a;
          mplier_q <= req_b;
          cnt_q    <= '0;
          mofl_q   <= 1'b0;
          rsp_data <= '0;
          rsp_ofl  <= 1'b0;
          rsp_err  <= (req_cmd > CMD_MUL);
        end
        S_EXEC: begin
          if (req_q.cmd == CMD_ROTR) begin
            shamt_q <= alu_out;
          end else begin
            rsp_data <= exec_data;
            rsp_ofl  <= exec_ofl;
          end
        end
        S_EXEC2: begin
          rsp_data <= alu_out;
          rsp_ofl  <= 1'b0;
        end
        S_MUL: begin
          acc_q    <= acc_n;
          mofl_q   <= mofl_n;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            rsp_data <= acc_n;
            rsp_ofl  <= mofl_n;
          end
        end
        default: ;
      endcase
    end
  end

  assign rsp_zero = rsp_valid && (rsp_data == '0);

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq with a behavioural 16-bit ALU attached to the alu_* ports.
module tb_alu_seq;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_ready;
  logic [3:0]  req_cmd = '0;
  logic [15:0] req_a = '0, req_b = '0;
  logic        rsp_valid, rsp_ready = 1'b0;
  logic [15:0] rsp_data;
  logic        rsp_zero, rsp_ofl, rsp_err;
  logic [15:0] alu_a, alu_b, alu_out;
  logic        alu_cin, alu_inva, alu_invb, alu_sign, alu_zero, alu_ofl;
  logic [2:0]  alu_op;
  int checks = 0;
  int errors = 0;
  int lat;

  alu_seq #(.N(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_zero(rsp_zero),
    .rsp_ofl(rsp_ofl), .rsp_err(rsp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_inva(alu_inva), .alu_invb(alu_invb),
    .alu_sign(alu_sign), .alu_op(alu_op), .alu_out(alu_out), .alu_zero(alu_zero), .alu_ofl(alu_ofl)
  );

  always #5 clk = ~clk;

  // Reference ALU: the block under test is only the sequencer.
  always_comb begin
    logic [15:0] x, y;
    logic [16:0] s;
    logic [31:0] xx;
    x = alu_inva ? ~alu_a : alu_a;
    y = alu_invb ? ~alu_b : alu_b;
    s = {1'b0, x} + {1'b0, y} + {16'b0, alu_cin};
    xx = {x, x} << y[3:0];
    alu_out = '0;
    alu_ofl = 1'b0;
    case (alu_op)
      3'd0: alu_out = xx[31:16];
      3'd1: alu_out = x << y[3:0];
      3'd2: alu_out = 16'($signed(x) >>> y[3:0]);
      3'd3: alu_out = x >> y[3:0];
      3'd4: begin
        alu_out = s[15:0];
        alu_ofl = alu_sign ? ((x[15] == y[15]) && (s[15] != x[15])) : s[16];
      end
      3'd5: alu_out = x | y;
      3'd6: alu_out = x ^ y;
      default: alu_out = x & y;
    endcase
    alu_zero = (alu_out == 16'h0);
  end

  // Called #1 after an edge with the DUT idle; lat counts from the handshake edge.
  task automatic issue(input logic [3:0] c, input logic [15:0] a, input logic [15:0] b, output int l);
    req_cmd = c; req_a = a; req_b = b; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    l = 1;
    while (!rsp_valid && l < 40) begin @(posedge clk); #1; l++; end
  endtask

  task automatic retire;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_req_ready got %b exp 1", req_ready); end
    checks++; if ({rsp_valid, rsp_zero, rsp_ofl, rsp_err} !== 4'b0) begin errors++; $display("FAIL rst_rsp_flags got %b exp 0000", {rsp_valid, rsp_zero, rsp_ofl, rsp_err}); end
    checks++; if (rsp_data !== 16'h0) begin errors++; $display("FAIL rst_rsp_data got %h exp 0000", rsp_data); end
    checks++; if ({alu_a, alu_b, alu_op, alu_cin, alu_inva, alu_invb, alu_sign} !== 39'h0) begin errors++; $display("FAIL rst_alu_drive got %h exp 0", {alu_a, alu_b, alu_op, alu_cin, alu_inva, alu_invb, alu_sign}); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_single;
    issue(4'd4, 16'h7FFF, 16'h0001, lat);
    checks++; if (lat !== 2) begin errors++; $display("FAIL add_latency got %0d exp 2", lat); end
    checks++; if (rsp_data !== 16'h8000) begin errors++; $display("FAIL add_data got %h exp 8000", rsp_data); end
    checks++; if ({rsp_ofl, rsp_zero, rsp_err} !== 3'b100) begin errors++; $display("FAIL add_flags got %b exp 100", {rsp_ofl, rsp_zero, rsp_err}); end
    retire();
    issue(4'd7, 16'h00F0, 16'h0F0F, lat);
    checks++; if (rsp_data !== 16'h0000) begin errors++; $display("FAIL and_data got %h exp 0000", rsp_data); end
    checks++; if ({rsp_ofl, rsp_zero} !== 2'b01) begin errors++; $display("FAIL and_flags got %b exp 01", {rsp_ofl, rsp_zero}); end
    retire();
    issue(4'd13, 16'h1234, 16'h5678, lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL rsvd_latency got %0d exp 1", lat); end
    checks++; if ({rsp_data, rsp_err} !== {16'h0, 1'b1}) begin errors++; $display("FAIL rsvd_resp got %h/%b exp 0000/1", rsp_data, rsp_err); end
    retire();
  endtask

  task automatic test_sub_slt;
    issue(4'd8, 16'h8000, 16'h0001, lat);
    checks++; if ({rsp_data, rsp_ofl, rsp_err} !== {16'h7FFF, 2'b10}) begin errors++; $display("FAIL sub_resp got %h/%b/%b exp 7fff/1/0", rsp_data, rsp_ofl, rsp_err); end
    retire();
    issue(4'd9, 16'h8000, 16'h0001, lat);
    checks++; if ({rsp_data, rsp_ofl} !== {16'h0001, 1'b0}) begin errors++; $display("FAIL slt_ovf got %h/%b exp 0001/0", rsp_data, rsp_ofl); end
    retire();
    issue(4'd9, 16'h0005, 16'hFFFD, lat);
    checks++; if ({rsp_data, rsp_zero} !== {16'h0000, 1'b1}) begin errors++; $display("FAIL slt_pos got %h/%b exp 0000/1", rsp_data, rsp_zero); end
    retire();
  endtask

  task automatic test_rotr;
    issue(4'd10, 16'h0001, 16'h0001, lat);
    checks++; if (lat !== 3) begin errors++; $display("FAIL rotr_latency got %0d exp 3", lat); end
    checks++; if (rsp_data !== 16'h8000) begin errors++; $display("FAIL rotr1_data got %h exp 8000", rsp_data); end
    retire();
    issue(4'd10, 16'h1234, 16'h0000, lat);
    checks++; if (rsp_data !== 16'h1234) begin errors++; $display("FAIL rotr0_data got %h exp 1234", rsp_data); end
    retire();
    issue(4'd10, 16'h00F1, 16'h0004, lat);
    checks++; if (rsp_data !== 16'h100F) begin errors++; $display("FAIL rotr4_data got %h exp 100f", rsp_data); end
    retire();
  endtask

  task automatic test_mul;
    issue(4'd11, 16'h0123, 16'h0010, lat);
    checks++; if (lat !== 17) begin errors++; $display("FAIL mul_latency got %0d exp 17", lat); end
    checks++; if ({rsp_data, rsp_ofl} !== {16'h1230, 1'b0}) begin errors++; $display("FAIL mul_small got %h/%b exp 1230/0", rsp_data, rsp_ofl); end
    retire();
    issue(4'd11, 16'hFFFF, 16'hFFFF, lat);
    checks++; if ({rsp_data, rsp_ofl} !== {16'h0001, 1'b1}) begin errors++; $display("FAIL mul_max got %h/%b exp 0001/1", rsp_data, rsp_ofl); end
    retire();
    issue(4'd11, 16'h0000, 16'hFFFF, lat);
    checks++; if ({rsp_data, rsp_zero} !== {16'h0000, 1'b1}) begin errors++; $display("FAIL mul_zero got %h/%b exp 0000/1", rsp_data, rsp_zero); end
    retire();
  endtask

  task automatic test_back_to_back;
    issue(4'd4, 16'h1234, 16'h0001, lat);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++; if ({rsp_valid, rsp_data, rsp_ofl, rsp_zero, rsp_err, req_ready} !== {1'b1, 16'h1235, 4'b0000}) begin errors++; $display("FAIL bp_hold%0d got %b/%h/%b exp 1/1235/0000", i, rsp_valid, rsp_data, {rsp_ofl, rsp_zero, rsp_err, req_ready}); end
      checks++; if ({alu_a, alu_b, alu_op, alu_cin, alu_inva, alu_invb, alu_sign} !== 39'h0) begin errors++; $display("FAIL bp_alu%0d got %h exp 0", i, {alu_a, alu_b, alu_op, alu_cin, alu_inva, alu_invb, alu_sign}); end
    end
    rsp_ready = 1'b1;
    req_cmd = 4'd8; req_a = 16'h0010; req_b = 16'h0003; req_valid = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    checks++; if ({rsp_valid, req_ready} !== 2'b01) begin errors++; $display("FAIL b2b_retire got %b exp 01", {rsp_valid, req_ready}); end
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL b2b_accept got %b exp 0", req_ready); end
    lat = 2;
    while (!rsp_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    checks++; if ({lat, rsp_data} !== {32'd3, 16'h000D}) begin errors++; $display("FAIL b2b_resp got %0d/%h exp 3/000d", lat, rsp_data); end
    retire();
  endtask

  task automatic test_reset_mid_mul;
    req_cmd = 4'd11; req_a = 16'h0003; req_b = 16'h0007; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++; if ({req_ready, rsp_valid, rsp_data, rsp_ofl, rsp_err} !== {2'b10, 16'h0, 2'b00}) begin errors++; $display("FAIL midrst_rsp got %b/%b/%h exp 1/0/0000", req_ready, rsp_valid, rsp_data); end
    checks++; if ({alu_a, alu_b, alu_op, alu_cin, alu_inva, alu_invb, alu_sign} !== 39'h0) begin errors++; $display("FAIL midrst_alu got %h exp 0", {alu_a, alu_b, alu_op, alu_cin, alu_inva, alu_invb, alu_sign}); end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL midrst_dropped got %b exp 0", rsp_valid); end
    issue(4'd11, 16'h0003, 16'h0007, lat);
    checks++; if ({lat, rsp_data, rsp_ofl} !== {32'd17, 16'h0015, 1'b0}) begin errors++; $display("FAIL midrst_next got %0d/%h/%b exp 17/0015/0", lat, rsp_data, rsp_ofl); end
    retire();
  endtask

  initial begin
    test_reset();
    test_single();
    test_sub_slt();
    test_rotr();
    test_mul();
    test_back_to_back();
    test_reset_mid_mul();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_seq.md
# alu_seq

Sequenced command front end for the 16-bit ALU: it accepts operation requests over a valid/ready handshake, drives the ALU control and operand ports, captures Out/Zero/Ofl, and returns a registered response. It is the initiator side of the ALU interface. It adds composite operations built from several ALU passes (subtract, signed set-less-than, rotate right, 16x16 low-half multiply), so the execute stage can issue them without knowing the ALU encoding.

## Interface
- N, 16, operand/result width (only 16 supported)
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid && req_ready
- req_cmd  in  4  command (see Operation)
- req_a, req_b  in  N  operands
- rsp_valid  out  1  response present; held until rsp_ready
- rsp_ready  in  1  consumer accepts response
- rsp_data  out  N  result
- rsp_zero  out  1  rsp_data == 0
- rsp_ofl  out  1  overflow as defined per command
- rsp_err  out  1  reserved command issued
- alu_a, alu_b  out  N  to ALU InA/InB
- alu_cin, alu_inva, alu_invb, alu_sign  out  1  to ALU Cin/invA/invB/sign
- alu_op  out  3  to ALU Op
- alu_out  in  N  from ALU Out
- alu_zero, alu_ofl  in  1  from ALU Zero/Ofl

## Operation
- ALU Op: 000 rotl, 001 shl, 010 sra, 011 srl (shift count = B[3:0]), 100 add, 101 or, 110 xor, 111 and. invA/invB complement before the op. Ofl is signed overflow when sign=1 and unsigned carry-out when sign=0.
- Commands:
  - 0-7: single pass, alu_op=cmd, inv=0, cin=0, sign=1. rsp_ofl=alu_ofl for cmd 4, else 0.
  - 8 SUB: A-B: op=100, invB=1, cin=1, sign=1. rsp_ofl=alu_ofl.
  - 9 SLT: same pass as SUB; rsp_data={15'b0, alu_out[15]^alu_ofl}; rsp_ofl=0.
  - 10 ROTR: pass 1 computes 0-B (A=0, invB=1, cin=1, op=100). Pass 2 runs rotl with A=req_a and B=pass-1 result. rsp_ofl=0.
  - 11 MUL: low 16 bits of unsigned A*B (see MUL below).
  - 12-15: no ALU pass; rsp_data=0, rsp_err=1.
- rsp_zero is always computed from the registered rsp_data, never from alu_zero.
- States: IDLE, EXEC, EXEC2, MUL, RESP.
  - IDLE: req_ready=1. On handshake, latch cmd/a/b, then go to EXEC (cmds 0-10), MUL (11), or RESP (12-15).
  - EXEC: drives pass 1. Go to RESP, except ROTR goes to EXEC2 and latches alu_out as its shift count.
  - EXEC2: drives pass 2, then RESP.
  - MUL: see below.
  - RESP: rsp_valid=1; all outputs stable. On rsp_ready go to IDLE.
- MUL:
  - Registers: acc=0, mcand=A, mplier=B, cnt=0, ofl=0.
  - Each of 16 cycles: drive alu_a=acc, alu_b=mcand, op=100, sign=0.
  - If mplier[0]=1: acc<=alu_out and ofl<=ofl|alu_ofl.
  - Every cycle: mcand<<=1, mplier>>=1, cnt++.
  - After cnt==15: go to RESP with rsp_data=acc and rsp_ofl=ofl. Bits shifted out of mcand are not flagged.
- ALU drive outside EXEC/EXEC2/MUL: all alu_* outputs are 0.

## Timing
- Reset (asynchronous): state=IDLE. req_ready=1. rsp_valid, rsp_data, rsp_zero, rsp_ofl, rsp_err, and all alu_* outputs = 0. Internal registers cleared.
- Reset mid-operation aborts the operation; the in-flight request is dropped with no response.
- req_ready is high only in IDLE. Only one request is in flight; no pipelining.
- Latency from the handshake edge T to the first cycle rsp_valid is high:
  - single-pass commands (0-9): T+2
  - ROTR: T+3
  - MUL: T+17
  - reserved commands: T+1
- Back-to-back: if the response is accepted at edge R, the next request can be accepted at R+1.
- rsp_ready high at the same time as rsp_valid retires the response that cycle. rsp_ready while not in RESP is ignored.
- req_valid may drop without a handshake; nothing is latched.

## Test plan
- Reset mid-MUL: assert rst during the MUL state → outputs return to reset values immediately; the next request executes correctly.
- Single-pass and reserved ops: cmd=4, a=0x7FFF, b=0x0001 → rsp_data=0x8000, rsp_ofl=1, rsp_zero=0, rsp_valid at T+2. Then cmd=7, a=0x00F0, b=0x0F0F → rsp_data=0x0000, rsp_zero=1. Then cmd=13 → rsp_data=0, rsp_err=1 at T+1.
- SUB and SLT: cmd=8, a=0x8000, b=0x0001 → rsp_data=0x7FFF, rsp_ofl=1. cmd=9 with the same operands → rsp_data=0x0001. cmd=9, a=5, b=-3 (0xFFFD) → rsp_data=0x0000, rsp_zero=1.
- ROTR: cmd=10, a=0x0001, b=0x0001 → rsp_data=0x8000 at T+3. cmd=10, b=0x0000 (count 0 wraps to rotl 0) → rsp_data=a.
- MUL: cmd=11, a=0x0123, b=0x0010 → rsp_data=0x1230, rsp_ofl=0 at T+17. a=0xFFFF, b=0xFFFF → rsp_data=0x0001, rsp_ofl=1. a=0, b=0xFFFF → rsp_zero=1.
- Backpressure: hold rsp_ready=0 for 5 cycles → rsp_data and flags stable, req_ready=0, and the alu_* outputs stay 0 throughout. rsp_ready=1 → the next request is accepted the following cycle.
